// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver with a valid/ready holding register.
//   The serial line passes through a two-flop synchroniser. Each bit is
//   decided by a majority vote of three samples taken around the middle of
//   the bit period, which is measured by counting tick_in pulses. The
//   frame completes half-way through the last stop bit so that a following
//   start edge is never missed.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick_in      one-clk pulse, OVERSAMPLE pulses per bit period
//   rx_data      serial line, idle high, asynchronous to clk
//   rx_ready     consumer accepts the held word this cycle
//   data_out     received word, stable while rx_valid is high
//   rx_valid     held word available
//   parity_err   parity mismatch on the held word
//   frame_err    a stop bit of the held word sampled low
//   overrun_err  an unconsumed word was overwritten by the held word
//   busy         receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_in,
  input  logic                 rx_data,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned MID    = OVERSAMPLE / 2;

  // Sample points around mid-bit and the last tick of a bit period
  localparam logic [SCNT_W-1:0] S_LO  = SCNT_W'(MID - 1);
  localparam logic [SCNT_W-1:0] S_MID = SCNT_W'(MID);
  localparam logic [SCNT_W-1:0] S_HI  = SCNT_W'(MID + 1);
  localparam logic [SCNT_W-1:0] S_END = SCNT_W'(OVERSAMPLE - 1);

  localparam logic [BCNT_W-1:0] B_LAST_DATA = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_LAST_STOP = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Frame tracking
  state_e                state_q, state_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [1:0]            samp_q, samp_d;
  logic                  vote_q, vote_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  // Holding register
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic                  ovr_err_q, ovr_err_d;
  logic                  busy_q, busy_d;

  // Synchroniser and edge detect
  logic                  meta_q;
  logic                  rx_s_q;
  logic                  rx_prev_q;

  logic                  fall_c;
  logic                  vote_c;
  logic                  bit_end_c;
  logic                  done_c;

  // Two-flop synchroniser plus one history flop for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      meta_q    <= rx_data;
      rx_s_q    <= meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_c    = rx_prev_q & ~rx_s_q;
  assign bit_end_c = (scnt_q == S_END);

  // Majority of the two stored samples and the one being taken now
  assign vote_c = (samp_q[0] & samp_q[1]) |
                  (samp_q[0] & rx_s_q)    |
                  (samp_q[1] & rx_s_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      samp_q    <= '0;
      vote_q    <= 1'b0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      samp_q    <= samp_d;
      vote_q    <= vote_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, bit sampling and holding-register update
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    samp_d    = samp_q;
    vote_d    = vote_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    ovr_err_d = ovr_err_q;
    done_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Edge detect runs every clk; a line held low cannot retrigger
        if (fall_c) begin
          state_d = ST_START;
          scnt_d  = '0;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      default: begin
        if (tick_in) begin
          scnt_d = bit_end_c ? '0 : scnt_q + SCNT_W'(1);
          if (scnt_q == S_LO)  samp_d[0] = rx_s_q;
          if (scnt_q == S_MID) samp_d[1] = rx_s_q;
          if (scnt_q == S_HI)  vote_d    = vote_c;

          case (state_q)
            ST_START: begin
              // A start bit that votes high was a glitch
              if (bit_end_c) state_d = vote_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
              if (bit_end_c) begin
                shift_d = {vote_q, shift_q[DATA_BITS-1:1]};
                if (bcnt_q == B_LAST_DATA) begin
                  bcnt_d  = '0;
                  state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
                end
              end
            end
            ST_PARITY: begin
              if (bit_end_c) begin
                perr_d  = ((^shift_q) ^ vote_q) != 1'(PARITY_ODD);
                state_d = ST_STOP;
              end
            end
            ST_STOP: begin
              // Last stop bit completes at the third sample, mid-bit
              if ((bcnt_q == B_LAST_STOP) && (scnt_q == S_HI)) begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
              end else if (bit_end_c) begin
                if (!vote_q) ferr_d = 1'b1;
                bcnt_d = bcnt_q + BCNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    // Consumer handshake drops the held word
    if (valid_q && rx_ready) begin
      valid_d   = 1'b0;
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
      ovr_err_d = 1'b0;
    end

    // A completing frame takes priority over the handshake clear
    if (done_c) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      par_err_d = perr_q;
      frm_err_d = ferr_q | ~vote_c;
      ovr_err_d = valid_q & ~rx_ready;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  assign data_out    = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = par_err_q;
  assign frame_err   = frm_err_q;
  assign overrun_err = ovr_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
//   Drives three receiver builds (8N1/16x, 8E1/16x, 7O2/8x) from a shared
//   tick generator. Frames are composed bit by bit from their serial
//   definition; expected word, flags and overrun state come from a small
//   per-receiver model of the holding register.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned TDIV = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  int         tdiv  = 0;
  int         cyc   = 0;
  logic       rx  [3];
  logic       rdy [3];

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, oe0, oe1, oe2, bz0, bz1, bz2;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pending [3];
  int         stop_cyc = 0;
  int         rise_cyc = 0;
  logic       v0_prev  = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tdiv <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
    tick <= (tdiv == TDIV - 1);
  end

  always @(negedge clk) begin
    if (v0 && !v0_prev) rise_cyc <= cyc;
    v0_prev <= v0;
  end

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_rx0 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .rx_data(rx[0]), .rx_ready(rdy[0]),
    .data_out(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0), .overrun_err(oe0), .busy(bz0));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_rx1 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .rx_data(rx[1]), .rx_ready(rdy[1]),
    .data_out(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1), .overrun_err(oe1), .busy(bz1));

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_rx2 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .rx_data(rx[2]), .rx_ready(rdy[2]),
    .data_out(d2), .rx_valid(v2), .parity_err(pe2), .frame_err(fe2), .overrun_err(oe2), .busy(bz2));

  // Per-build frame format
  function automatic int nb(input int u);   return (u == 2) ? 7 : 8;  endfunction
  function automatic int osr(input int u);  return (u == 2) ? 8 : 16; endfunction
  function automatic bit pen(input int u);  return (u != 0);          endfunction
  function automatic bit podd(input int u); return (u == 2);          endfunction
  function automatic int nst(input int u);  return (u == 2) ? 2 : 1;  endfunction

  function automatic logic [8:0] f_data(input int u);
    case (u)
      0:       return 9'(d0);
      1:       return 9'(d1);
      default: return 9'(d2);
    endcase
  endfunction

  // {valid, parity_err, frame_err, overrun_err, busy}
  function automatic logic [4:0] f_flags(input int u);
    case (u)
      0:       return {v0, pe0, fe0, oe0, bz0};
      1:       return {v1, pe1, fe1, oe1, bz1};
      default: return {v2, pe2, fe2, oe2, bz2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One bit period of bp clocks, optionally with a one-tick inverted pulse mid-bit
  task automatic drive_bit(input int u, input logic b, input int bp, input bit glitch);
    @(negedge clk);
    rx[u] = b;
    if (glitch) begin
      repeat (bp / 2 - 2) @(negedge clk);
      rx[u] = ~b;
      repeat (TDIV) @(negedge clk);
      rx[u] = b;
      repeat (bp - 1 - (bp / 2 - 2) - TDIV) @(negedge clk);
    end else begin
      repeat (bp - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int u, input logic [8:0] d, input bit bad_par,
                            input logic [1:0] stop_v, input int glitch_bit, output logic pbit);
    int bp;
    bp   = osr(u) * TDIV;
    pbit = 1'b0;
    drive_bit(u, 1'b0, bp, 1'b0);
    for (int i = 0; i < nb(u); i++) drive_bit(u, d[i], bp, i == glitch_bit);
    if (pen(u)) begin
      pbit = (^d) ^ podd(u) ^ bad_par;
      drive_bit(u, pbit, bp, 1'b0);
    end
    for (int i = 0; i < nst(u); i++) begin
      if (i == nst(u) - 1) stop_cyc = cyc;
      drive_bit(u, stop_v[i], bp, 1'b0);
    end
  endtask

  task automatic line_idle(input int u, input int n);
    @(negedge clk);
    rx[u] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Model: word, parity rule over the transmitted bits, any low stop bit, overrun
  task automatic expect_word(input int u, input string tag, input logic [8:0] d,
                             input logic pbit, input logic [1:0] stop_v);
    logic [4:0] f;
    int         ones;
    logic       exp_pe, exp_fe;
    f = f_flags(u);
    for (int i = 0; i < 16 && f[4] == 1'b0; i++) begin
      @(negedge clk);
      f = f_flags(u);
    end
    ones   = $countones(d) + (pbit ? 1 : 0);
    exp_pe = pen(u) && ((ones % 2) != (podd(u) ? 1 : 0));
    exp_fe = (stop_v[0] == 1'b0) || (nst(u) == 2 && stop_v[1] == 1'b0);
    check({tag, "/valid"},  32'(f[4]), 32'd1);
    check({tag, "/data"},   32'(f_data(u)), 32'(d));
    check({tag, "/parity"}, 32'(f[3]), 32'(exp_pe));
    check({tag, "/frame"},  32'(f[2]), 32'(exp_fe));
    check({tag, "/overrun"}, 32'(f[1]), 32'(pending[u]));
    pending[u] = 1;
  endtask

  task automatic consume(input int u, input string tag);
    logic [4:0] f;
    @(negedge clk);
    rdy[u] = 1'b1;
    @(negedge clk);
    rdy[u] = 1'b0;
    f = f_flags(u);
    check({tag, "/cleared"}, 32'(f[4:1]), 32'd0);
    pending[u] = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         u, bp, diff, nf;
    logic [8:0] d;
    bit         bad;
    logic [1:0] sv;
    logic       pb;
    logic [4:0] f;

    for (int i = 0; i < 3; i++) begin
      rx[i]      = 1'b1;
      rdy[i]     = 1'b0;
      pending[i] = 0;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset/flags", 32'(f_flags(i)), 32'd0);
      check("reset/data", 32'(f_data(i)), 32'd0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 8N1 0xA5, completion lands mid-way through the stop bit
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, pb);
    diff = rise_cyc - stop_cyc;
    check("t1/valid_mid_stop", 32'(diff >= 36 && diff <= 48), 32'd1);
    expect_word(0, "t1", 9'h0A5, pb, 2'b11);
    line_idle(0, 16);
    consume(0, "t1");

    // Short low pulse is rejected as a false start
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (4 * TDIV) @(negedge clk);
    rx[0] = 1'b1;
    f = f_flags(0);
    check("t2/busy_during", 32'(f[0]), 32'd1);
    repeat (128) @(negedge clk);
    f = f_flags(0);
    check("t2/busy_after", 32'(f[0]), 32'd0);
    check("t2/no_valid", 32'(f[4]), 32'd0);

    // One-tick glitch inside a data bit is outvoted
    send_frame(0, 9'h000, 1'b0, 2'b11, 3, pb);
    expect_word(0, "t2g", 9'h000, pb, 2'b11);
    line_idle(0, 16);
    consume(0, "t2g");

    // Even parity: wrong then right parity bit
    send_frame(1, 9'h03C, 1'b1, 2'b11, -1, pb);
    check("t3/pbit_sent", 32'(pb), 32'd1);
    expect_word(1, "t3bad", 9'h03C, pb, 2'b11);
    line_idle(1, 16);
    consume(1, "t3bad");
    send_frame(1, 9'h03C, 1'b0, 2'b11, -1, pb);
    expect_word(1, "t3ok", 9'h03C, pb, 2'b11);
    line_idle(1, 16);
    consume(1, "t3ok");

    // Low stop bit, then a clean frame after a line-high gap
    send_frame(0, 9'h055, 1'b0, 2'b10, -1, pb);
    line_idle(0, 64);
    expect_word(0, "t4bad", 9'h055, pb, 2'b10);
    consume(0, "t4bad");
    send_frame(0, 9'h00F, 1'b0, 2'b11, -1, pb);
    expect_word(0, "t4ok", 9'h00F, pb, 2'b11);
    line_idle(0, 16);
    consume(0, "t4ok");

    // Back-to-back frames without consuming: overrun
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, pb);
    pending[0] = 1;
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, pb);
    expect_word(0, "t5", 9'h022, pb, 2'b11);
    line_idle(0, 16);
    consume(0, "t5");

    // Reset in the middle of a frame
    bp = osr(0) * TDIV;
    drive_bit(0, 1'b0, bp, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, bp, 1'b0);
    f = f_flags(0);
    check("t6/busy_pre", 32'(f[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t6/flags", 32'(f_flags(0)), 32'd0);
    check("t6/data", 32'(f_data(0)), 32'd0);
    for (int i = 0; i < 3; i++) pending[i] = 0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(0, 9'h07E, 1'b0, 2'b11, -1, pb);
    expect_word(0, "t6a", 9'h07E, pb, 2'b11);
    line_idle(0, 16);
    consume(0, "t6a");
    send_frame(2, 9'h07E, 1'b0, 2'b11, -1, pb);
    expect_word(2, "t6b", 9'h07E, pb, 2'b11);
    line_idle(2, 16);
    consume(2, "t6b");

    // Randomised frames across all builds
    nf = 30;
    for (int k = 0; k < nf; k++) begin
      u   = $urandom_range(0, 2);
      bp  = osr(u) * TDIV;
      d   = 9'($urandom) & 9'((1 << nb(u)) - 1);
      bad = ($urandom_range(0, 3) == 0);
      sv  = 2'b11;
      if ($urandom_range(0, 3) == 0) sv[$urandom_range(0, nst(u) - 1)] = 1'b0;
      send_frame(u, d, bad, sv, -1, pb);
      if (sv[nst(u) - 1] == 1'b0) line_idle(u, bp);
      expect_word(u, "rnd", d, pb, sv);
      line_idle(u, $urandom_range(1, bp));
      if ($urandom_range(0, 1) == 1) consume(u, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
